model_layer_node_unit_divider: RTL

MODEL_LAYER_NODE_UNIT_DIVIDER -- requirements
Module: model_layer_node_unit_divider

---
 rtl/model_node_fp_pkg.sv | 18 +
 rtl/model_layer_node_unit_fp_round.sv | 41 ++++
 rtl/model_layer_node_unit_divider.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/model_node_fp_pkg.sv
// Shared single-precision constants and the divider FSM state encoding.
package model_node_fp_pkg;

   localparam int unsigned FP_BIAS  = 127;
   localparam int unsigned FP_EXP_W = 8;
   localparam int unsigned FP_MAN_W = 23;
   localparam int unsigned DIV_ITER = 26;
   localparam int unsigned EXP_S_W  = 10;
   localparam int unsigned CNT_W    = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } div_state_e;

endpackage

// File: rtl/model_layer_node_unit_fp_round.sv
// Round-to-nearest-even, overflow (saturate or infinity) and flush-to-zero
// for a normalized single-precision result; purely combinational.
module model_layer_node_unit_fp_round
   import model_node_fp_pkg::*;
#(
   parameter bit OVF_SAT = 1'b1
) (
   input  logic                       i_sign,
   input  logic signed [EXP_S_W-1:0]  i_exp,
   input  logic [FP_MAN_W-1:0]        i_man,
   input  logic                       i_guard,
   input  logic                       i_round,
   input  logic                       i_sticky,
   output logic [31:0]                o_res_c
);

   localparam logic signed [EXP_S_W-1:0] EXP_MAX = EXP_S_W'(254);
   localparam logic signed [EXP_S_W-1:0] EXP_MIN = EXP_S_W'(1);

   logic                      w_inc;
   logic [FP_MAN_W:0]         w_man_sum;
   logic signed [EXP_S_W-1:0] w_exp;

   // A mantissa carry-out leaves the low bits at zero, so only the exponent moves.
   always_comb begin
      w_inc     = i_guard & (i_round | i_sticky | i_man[0]);
      w_man_sum = {1'b0, i_man} + (FP_MAN_W + 1)'(w_inc);
      w_exp     = i_exp + EXP_S_W'(w_man_sum[FP_MAN_W]);
      if (w_exp > EXP_MAX) begin
         if (OVF_SAT)
            o_res_c = {i_sign, 8'hFE, 23'h7FFFFF};
         else
            o_res_c = {i_sign, 8'hFF, 23'h000000};
      end else if (w_exp < EXP_MIN) begin
         o_res_c = {i_sign, 31'b0};
      end else begin
         o_res_c = {i_sign, w_exp[FP_EXP_W-1:0], w_man_sum[FP_MAN_W-1:0]};
      end
   end

endmodule

// File: rtl/model_layer_node_unit_divider.sv
// Iterative IEEE-754 single-precision divider (restoring, one bit per cycle).
// Optional zero/divide-by-zero handling with dz flag: NODE_DIV_SPECIAL_EN.
module model_layer_node_unit_divider
   import model_node_fp_pkg::*;
#(
   parameter bit OVF_SAT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] c
`ifdef NODE_DIV_SPECIAL_EN
   ,
   output logic        dz
`endif
);

   div_state_e                r_state;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_sign;
   logic signed [EXP_S_W-1:0] r_exp;
   logic [24:0]               r_rem;
   logic [23:0]               r_mb;
   logic [DIV_ITER-1:0]       r_quo;
   logic                      r_rnd_ph;
`ifdef NODE_DIV_SPECIAL_EN
   logic                      r_spec;
   logic                      r_dz;
   logic [31:0]               r_spec_res;
   logic                      w_a_zero;
   logic                      w_b_zero;
`endif

   logic [25:0]               w_diff;
   logic                      w_ge;
   logic [24:0]               w_rem_nxt;
   logic                      w_norm;
   logic [FP_MAN_W-1:0]       w_man;
   logic                      w_guard;
   logic                      w_round;
   logic                      w_sticky;
   logic signed [EXP_S_W-1:0] w_exp;
   logic [31:0]               w_res_c;

   // One restoring step; the remainder always stays below twice the divisor.
   always_comb begin
      w_diff    = {1'b0, r_rem} - {2'b0, r_mb};
      w_ge      = ~w_diff[25];
      w_rem_nxt = (w_ge ? w_diff[24:0] : r_rem) << 1;
   end

   // Quotient below 1.0 needs one left shift; the lost round bit folds into sticky.
   always_comb begin
      w_norm   = r_quo[DIV_ITER-1];
      w_man    = w_norm ? r_quo[24:2] : r_quo[23:1];
      w_guard  = w_norm ? r_quo[1]    : r_quo[0];
      w_round  = w_norm ? r_quo[0]    : 1'b0;
      w_sticky = |r_rem;
      w_exp    = w_norm ? r_exp : r_exp - EXP_S_W'(1);
   end

`ifdef NODE_DIV_SPECIAL_EN
   always_comb begin
      w_a_zero = (a[30:23] == 8'h00);
      w_b_zero = (b[30:23] == 8'h00);
   end
`endif

   model_layer_node_unit_fp_round #(
      .OVF_SAT (OVF_SAT)
   ) u_round (
      .i_sign   (r_sign),
      .i_exp    (w_exp),
      .i_man    (w_man),
      .i_guard  (w_guard),
      .i_round  (w_round),
      .i_sticky (w_sticky),
      .o_res_c  (w_res_c)
   );

   // Control FSM; ROUND spends one cycle loading c, then raises out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_exp      <= '0;
         r_rem      <= '0;
         r_mb       <= '0;
         r_quo      <= '0;
         r_rnd_ph   <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         c          <= '0;
`ifdef NODE_DIV_SPECIAL_EN
         r_spec     <= 1'b0;
         r_dz       <= 1'b0;
         r_spec_res <= '0;
         dz         <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  r_sign   <= a[31] ^ b[31];
                  r_exp    <= EXP_S_W'(a[30:23]) - EXP_S_W'(b[30:23]) + EXP_S_W'(FP_BIAS);
                  r_rem    <= {1'b0, 1'b1, a[22:0]};
                  r_mb     <= {1'b1, b[22:0]};
                  r_quo    <= '0;
                  r_cnt    <= '0;
                  r_rnd_ph <= 1'b0;
`ifdef NODE_DIV_SPECIAL_EN
                  r_spec     <= w_a_zero | w_b_zero;
                  r_dz       <= w_b_zero;
                  r_spec_res <= w_b_zero ? {a[31] ^ b[31], 8'hFF, 23'h0}
                                         : {a[31] ^ b[31], 31'b0};
                  r_state    <= (w_a_zero | w_b_zero) ? ROUND : CALC;
`else
                  r_state  <= CALC;
`endif
               end
            end
            CALC: begin
               r_quo <= {r_quo[DIV_ITER-2:0], w_ge};
               r_rem <= w_rem_nxt;
               if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                  r_cnt   <= '0;
                  r_state <= ROUND;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ROUND: begin
               if (!r_rnd_ph) begin
                  r_rnd_ph <= 1'b1;
`ifdef NODE_DIV_SPECIAL_EN
                  c  <= r_spec ? r_spec_res : w_res_c;
                  dz <= r_dz;
`else
                  c  <= w_res_c;
`endif
               end else begin
                  r_rnd_ph  <= 1'b0;
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
